// File: rtl/game_ram_arbiter.sv
// Round-robin arbiter between the CPU (m0) and video fetch (m1) masters for the
// single-port game RAM, with a zero-fill clear engine and out-of-range accounting.
module game_ram_arbiter #(
  parameter int DEPTH = 25600,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] m0_address,
  input  logic [3:0]    m0_byteenable,
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [31:0]   m0_writedata,
  output logic          m0_waitrequest,
  output logic [31:0]   m0_readdata,
  output logic          m0_readdatavalid,
  input  logic [AW-1:0] m1_address,
  input  logic [3:0]    m1_byteenable,
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [31:0]   m1_writedata,
  output logic          m1_waitrequest,
  output logic [31:0]   m1_readdata,
  output logic          m1_readdatavalid,
  output logic [AW-1:0] ram_address,
  output logic [3:0]    ram_byteenable,
  output logic [31:0]   ram_writedata,
  output logic          ram_chipselect,
  output logic          ram_write,
  output logic          ram_clken,
  input  logic [31:0]   ram_readdata,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic          clear_done,
  output logic [15:0]   oor_count
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_e;

  state_e        state_q;
  logic [AW-1:0] clr_cnt_q;
  logic          last_grant_q, last_grant_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          rd_oor_q;
  logic          clear_done_q;
  logic [15:0]   oor_count_q, oor_count_d;

  logic          req0, req1, gnt0, gnt1, gnt_any;
  logic [AW-1:0] g_addr;
  logic [3:0]    g_be;
  logic [31:0]   g_wdata;
  logic          g_wr, g_oor;

  // Grant selection: last_grant_q names the master served most recently, so the other wins a tie.
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && state_q == S_IDLE) begin
      if (req0 && (!req1 || last_grant_q)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end else begin
        gnt1 = 1'b0;
      end
    end else begin
      gnt0 = 1'b0;
    end
    gnt_any = gnt0 | gnt1;
    g_addr  = gnt1 ? m1_address    : m0_address;
    g_be    = gnt1 ? m1_byteenable : m0_byteenable;
    g_wdata = gnt1 ? m1_writedata  : m0_writedata;
    g_wr    = gnt1 ? m1_write      : m0_write;
    g_oor   = g_addr > LAST_ADDR;
  end

  // Next-state values for the arbitration bookkeeping registers.
  always_comb begin
    last_grant_d = gnt_any ? gnt1 : last_grant_q;
    rvalid0_d    = gnt0 & ~m0_write;
    rvalid1_d    = gnt1 & ~m1_write;
    if (gnt_any && g_oor && oor_count_q != 16'hFFFF) begin
      oor_count_d = oor_count_q + 16'd1;
    end else begin
      oor_count_d = oor_count_q;
    end
  end

  // RAM port drive; out-of-range grants are accepted without touching the RAM.
  always_comb begin
    ram_address    = '0;
    ram_byteenable = 4'h0;
    ram_writedata  = 32'h0;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    if (reset) begin
      ram_chipselect = 1'b0;
    end else if (state_q == S_CLEAR) begin
      ram_address    = clr_cnt_q;
      ram_byteenable = 4'hF;
      ram_chipselect = 1'b1;
      ram_write      = 1'b1;
    end else if (gnt_any && !g_oor) begin
      ram_address    = g_addr;
      ram_byteenable = g_wr ? g_be : 4'hF;
      ram_writedata  = g_wdata;
      ram_chipselect = 1'b1;
      ram_write      = g_wr;
    end else begin
      ram_chipselect = 1'b0;
    end
  end

  // Control FSM, clear counter and read-return pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      clr_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rd_oor_q     <= 1'b0;
      clear_done_q <= 1'b0;
      oor_count_q  <= 16'h0;
    end else begin
      last_grant_q <= last_grant_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rd_oor_q     <= g_oor;
      oor_count_q  <= oor_count_d;
      clear_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clear_start) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
          end else begin
            state_q   <= S_IDLE;
          end
        end
        S_CLEAR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_q      <= S_IDLE;
            clr_cnt_q    <= '0;
            clear_done_q <= 1'b1;
          end else begin
            clr_cnt_q    <= clr_cnt_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m0_waitrequest   = ~gnt0;
  assign m1_waitrequest   = ~gnt1;
  assign m0_readdatavalid = rvalid0_q;
  assign m1_readdatavalid = rvalid1_q;
  // RAM q only exists in the cycle after the read, so the return data is muxed rather than registered.
  assign m0_readdata      = (rvalid0_q && !rd_oor_q) ? ram_readdata : 32'h0;
  assign m1_readdata      = (rvalid1_q && !rd_oor_q) ? ram_readdata : 32'h0;
  assign ram_clken        = ~reset;
  assign clear_busy       = (state_q == S_CLEAR);
  assign clear_done       = clear_done_q;
  assign oor_count        = oor_count_q;

endmodule

// File: doc/game_ram_arbiter.md
# game_ram_arbiter

Two-master arbiter and sequencer for the game's single-port on-chip RAM (32-bit words, 25600 deep, 15-bit word address, one-cycle read latency). It shares the RAM port between the CPU data master (m0) and the sprite/video fetch master (m1) with round-robin fairness. It also contains a clear engine that zero-fills the whole RAM on request. It sits between the two masters and the RAM's s1 port, and drives chipselect, write, byteenable and clken to the RAM.

## Interface
- DEPTH, 25600, number of valid words; addresses >= DEPTH are out of range
- AW, 15, word address width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- mN_address  in  AW  word address, N = 0, 1
- mN_byteenable  in  4  byte lanes for writes
- mN_read, mN_write  in  1  request strobes; read and write asserted together is treated as a write
- mN_writedata  in  32  write data
- mN_waitrequest  out  1  combinational; 0 means the request is accepted this cycle
- mN_readdata  out  32  read data
- mN_readdatavalid  out  1  read data qualifier
- ram_address  out  AW;  ram_byteenable  out  4;  ram_writedata  out  32
- ram_chipselect, ram_write, ram_clken  out  1
- ram_readdata  in  32  RAM q, valid one cycle after the address is presented
- clear_start  in  1  pulse that requests a zero-fill
- clear_busy  out  1  clear engine active
- clear_done  out  1  one-cycle pulse after the final clear write
- oor_count  out  16  saturating count of out-of-range accesses

## Operation
- FSM states: IDLE (arbitrating) and CLEAR. Reset enters IDLE.
- Transitions: IDLE->CLEAR when clear_start=1; CLEAR->IDLE after the write to address DEPTH-1.
- clear_start in CLEAR is ignored.
- IDLE arbitration:
  - A master requests when read or write is 1.
  - Only one requester: it is granted.
  - Both requesting: the master not granted last is granted.
  - last_grant updates only on a grant; reset value = 1, so m0 wins the first tie.
- Grant: waitrequest=0 for the granted master, 1 for the other requester. A non-requesting master sees waitrequest=1.
- Granted in-range access drives the RAM port:
  - ram_address = mN_address, ram_chipselect=1, ram_write = write.
  - ram_byteenable = mN_byteenable on writes, 4'hF on reads.
- Granted out-of-range access (address >= DEPTH):
  - Accepted with no RAM write; oor_count increments, saturating at 16'hFFFF.
  - A read of this kind returns 32'h0 with the normal latency.
- Read return: one cycle after a granted read, mN_readdatavalid=1 for exactly that master, and mN_readdata = ram_readdata (or 0 if out of range).
- CLEAR:
  - One write per cycle: ram_write=1, ram_byteenable=4'hF, ram_writedata=0, ram_address = counter 0..DEPTH-1.
  - Both masters see waitrequest=1 throughout.
- A clear_start cycle is still an IDLE cycle: any grant in that cycle completes, including its readdatavalid on the first CLEAR cycle.
- ram_clken = 1 always, except 0 while reset=1.
- Reset mid-clear aborts the fill immediately:
  - clear_busy=0, no clear_done pulse, counter=0.
  - RAM contents are partially cleared; this is legal.

## Timing
- Reset values:
  - mN_readdatavalid=0, mN_readdata=0, clear_busy=0, clear_done=0, oor_count=0.
  - ram_chipselect=0, ram_write=0, ram_address=0.
  - mN_waitrequest=1 while reset=1.
- Grant decision and RAM drive are combinational from the requests and registered state; accept-to-RAM latency is 0 cycles.
- Read latency is 1 cycle: request accepted in cycle T, readdatavalid in T+1.
- Throughput is one access per cycle. Back-to-back reads from alternating masters are pipelined with no bubbles.
- Clear timing:
  - clear_start in cycle T: clear_busy=1 from T+1, writes to addresses 0..DEPTH-1 in T+1..T+DEPTH.
  - clear_done=1 in T+DEPTH+1 and clear_busy=0 in T+DEPTH+1, back in IDLE.
  - A full clear takes DEPTH+1 cycles from start to done.
- The clear address counter is AW bits and is compared against DEPTH-1. It never wraps to out-of-range addresses.

## Test plan
- m0 writes 32'hDEADBEEF to address 5 with byteenable 4'hF; m0 then reads address 5. Required: waitrequest=0 on both; readdatavalid exactly 1 cycle after the read, readdata=32'hDEADBEEF.
- Both masters hold reads every cycle for 8 cycles, m0 at address 1, m1 at address 2. Required: grants alternate m0,m1,m0,... starting with m0; each master gets 4 readdatavalid pulses carrying its own data.
- m1 writes to address 25600, then reads it. Required: RAM contents unchanged (read back address 0 is intact), read returns 0, oor_count=2.
- Byte-lane write: write 32'h11223344 to address 9, then write 32'hAABBCCDD with byteenable 4'b0101 to address 9. Required: read returns 32'h11BB33DD.
- clear_start after filling addresses 0, 100 and 25599 with nonzero data. Required: clear_busy high for 25600 cycles; a m0 request issued meanwhile stalls until clear_done; all three addresses then read 0.
- reset asserted 50 cycles into a clear. Required: clear_busy=0 the next cycle, no clear_done pulse, address 60 still holds its old value, and arbitration resumes normally.
